// File: rtl/pcg_pkg.sv
// +----------------------------------------------------------------------------+
// | pcg_pkg                                                                    |
// | Shared constants and helpers for the PCG sound back end.                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package pcg_pkg;

  localparam logic [1:0] ADR_SND_EN  = 2'd0;
  localparam logic [1:0] ADR_SND_V01 = 2'd1;
  localparam logic [1:0] ADR_SND_V2B = 2'd2;

  localparam int LEVEL_W   = 8;
  localparam int VOL_W     = 3;
  localparam int MIX_SCALE = 9;
  localparam int NUM_SRC   = 4;
  localparam int SUM_W     = 5;

  // x9 as (x << 3) + x; 28 * 9 = 252 so the result never wraps.
  function automatic logic [LEVEL_W-1:0] scale_mix(input logic [SUM_W-1:0] sum);
    return {sum, 3'b000} + {3'b000, sum};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pcg_ds_dac.sv
// +----------------------------------------------------------------------------+
// | pcg_ds_dac                                                                 |
// | 8-bit first-order delta-sigma modulator driving a 1-bit RC-filtered pin.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pcg_ds_dac
  import pcg_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [LEVEL_W-1:0] level,
  output logic               dout
);

  logic [LEVEL_W-1:0] acc;
  logic [LEVEL_W:0]   acc_sum;

  assign acc_sum = {1'b0, acc} + {1'b0, level};

  // The carry out is the output bit; acc wraps, so a constant level L
  // yields exactly L ones per 256 cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      dout <= 1'b0;
    end else begin
      acc  <= acc_sum[LEVEL_W-1:0];
      dout <= acc_sum[LEVEL_W];
    end
  end

endmodule

`default_nettype wire

// File: rtl/pcg_sound_mixer.sv
// +----------------------------------------------------------------------------+
// | pcg_sound_mixer                                                            |
// | Syncs timer tones and beeper, applies enable/volume, mixes, drives DAC.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pcg_sound_mixer
  import pcg_pkg::*;
#(
  parameter int               SYNC_STAGES = 2,
  parameter logic [VOL_W-1:0] DEF_VOL     = 3'd4,
  parameter logic [3:0]       DEF_EN      = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         adr,
  input  logic [7:0]         din,
  input  logic               wr,
  input  logic [2:0]         tone_in,
  input  logic               beep_in,
  output logic [LEVEL_W-1:0] level,
  output logic               dout
);

  logic [NUM_SRC-1:0] async_in;
  logic [NUM_SRC-1:0] synced;

  assign async_in = {beep_in, tone_in};

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) chain <= '0;
        else     chain <= {chain[SYNC_STAGES-2:0], async_in[i]};
      end
      assign synced[i] = chain[SYNC_STAGES-1];
    end
  endgenerate

  // Register file: one write per rising edge of the level-sensitive wr.
  logic             wr_prev;
  logic             wr_accept;
  logic [3:0]       en;
  logic [VOL_W-1:0] vol0, vol1, vol2, volb;
  logic             unused_din;

  assign wr_accept  = wr & ~wr_prev;
  assign unused_din = din[7] ^ din[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_prev <= 1'b0;
      en      <= DEF_EN;
      vol0    <= DEF_VOL;
      vol1    <= DEF_VOL;
      vol2    <= DEF_VOL;
      volb    <= DEF_VOL;
    end else begin
      wr_prev <= wr;
      if (wr_accept) begin
        case (adr)
          ADR_SND_EN:  en <= din[3:0];
          ADR_SND_V01: begin
            vol0 <= din[2:0];
            vol1 <= din[6:4];
          end
          ADR_SND_V2B: begin
            vol2 <= din[2:0];
            volb <= din[6:4];
          end
          default: ;
        endcase
      end
    end
  end

  logic [VOL_W-1:0] vol_arr [NUM_SRC];
  logic [SUM_W-1:0] mix_sum;

  assign vol_arr[0] = vol0;
  assign vol_arr[1] = vol1;
  assign vol_arr[2] = vol2;
  assign vol_arr[3] = volb;

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (synced[i] && en[i]) mix_sum = mix_sum + {{(SUM_W-VOL_W){1'b0}}, vol_arr[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level <= '0;
    else     level <= scale_mix(mix_sum);
  end

  pcg_ds_dac u_dac (
    .clk   (clk),
    .rst   (rst),
    .level (level),
    .dout  (dout)
  );

endmodule

`default_nettype wire

// File: tb/tb_pcg_sound_mixer.sv
// Directed bench for pcg_sound_mixer: expected values are queued when stimulus
// is applied and popped when the corresponding output is sampled.
`default_nettype none

module tb_pcg_sound_mixer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] adr = '0;
  logic [7:0] din = '0;
  logic       wr  = 1'b0;
  logic [2:0] tone_drv = '0;
  logic       async_tone = 1'b0;
  logic       async_run = 1'b0;
  logic       beep_in = 1'b0;
  logic [2:0] tone_in;
  logic [7:0] level;
  logic       dout;

  assign tone_in = tone_drv | {1'b0, async_tone, 1'b0};

  pcg_sound_mixer dut (
    .clk     (clk),
    .rst     (rst),
    .adr     (adr),
    .din     (din),
    .wr      (wr),
    .tone_in (tone_in),
    .beep_in (beep_in),
    .level   (level),
    .dout    (dout)
  );

  always #5 clk = ~clk;

  // 2 MHz square wave, phase unrelated to the 100 MHz clock.
  initial begin
    #3.7;
    forever begin
      #250;
      if (async_run) async_tone = ~async_tone;
      else           async_tone = 1'b0;
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic check_obs(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty: observed=%0d expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [7:0] d);
    adr = a; din = d; wr = 1'b1;
    step();
    wr = 1'b0;
    step();
  endtask

  task automatic count_dout(output int n);
    n = 0;
    repeat (256) begin
      step();
      n += int'(dout);
    end
  endtask

  int ones;
  int seen0;
  int seen27;

  initial begin
    // 1: reset defaults
    tone_drv = 3'b111; beep_in = 1'b1;
    rst = 1'b1;
    step(3);
    expect_val("rst_level", 0);      check_obs({24'd0, level});
    expect_val("rst_dout", 0);       check_obs({31'd0, dout});
    rst = 1'b0;
    step(2);
    expect_val("sync_latency_before", 0); check_obs({24'd0, level});
    step(1);
    expect_val("default_level", 144);     check_obs({24'd0, level});
    count_dout(ones);
    expect_val("default_dout_count", 144); check_obs(ones);

    // 2: single channel
    tone_drv = 3'b001; beep_in = 1'b0;
    reg_write(2'd0, 8'h01);
    step(3);
    expect_val("ch0_vol4_level", 36); check_obs({24'd0, level});
    adr = 2'd1; din = 8'h07; wr = 1'b1;
    step();
    expect_val("write_edge_old_level", 36); check_obs({24'd0, level});
    wr = 1'b0;
    step();
    expect_val("ch0_vol7_level", 63); check_obs({24'd0, level});
    count_dout(ones);
    expect_val("ch0_dout_count", 63); check_obs(ones);
    tone_drv = 3'b000;
    step(2);
    expect_val("ch0_off_before", 63); check_obs({24'd0, level});
    step(1);
    expect_val("ch0_off_level", 0);   check_obs({24'd0, level});
    count_dout(ones);
    expect_val("zero_dout_count", 0); check_obs(ones);

    // 3: full scale
    tone_drv = 3'b111; beep_in = 1'b1;
    reg_write(2'd0, 8'h0F);
    reg_write(2'd1, 8'h77);
    reg_write(2'd2, 8'h77);
    step(3);
    expect_val("full_level", 252);      check_obs({24'd0, level});
    count_dout(ones);
    expect_val("full_dout_count", 252); check_obs(ones);

    // 4: held wr is one write; adr 3 ignored; unused din bits ignored
    adr = 2'd0; din = 8'h01; wr = 1'b1;
    step();
    din = 8'h0F;
    step(4);
    wr = 1'b0;
    step(2);
    expect_val("held_wr_level", 63); check_obs({24'd0, level});
    reg_write(2'd3, 8'hFF);
    step(2);
    expect_val("adr3_level", 63);    check_obs({24'd0, level});
    reg_write(2'd1, 8'h8B);
    step(1);
    expect_val("unused_bits_level", 27); check_obs({24'd0, level});

    // 5: asynchronous tone on ch1, vol 3
    tone_drv = 3'b000; beep_in = 1'b0;
    reg_write(2'd0, 8'h02);
    reg_write(2'd1, 8'h30);
    step(3);
    async_run = 1'b1;
    seen0 = 0; seen27 = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      total++;
      assert ((level === 8'd0) || (level === 8'd27)) else begin
        bad++;
        $error("FAIL async_level: observed=%0d expected=0_or_27", level);
      end
      total++;
      assert (!$isunknown(dout)) else begin
        bad++;
        $error("FAIL async_dout_x: observed=%b expected=0_or_1", dout);
      end
      if (level === 8'd0)  seen0  = 1;
      if (level === 8'd27) seen27 = 1;
    end
    expect_val("async_seen_both", 1); check_obs(seen0 & seen27);
    async_run = 1'b0;
    step(300);

    // 6: reset mid-stream, off clock edge
    tone_drv = 3'b111; beep_in = 1'b1;
    reg_write(2'd0, 8'h0F);
    reg_write(2'd1, 8'h77);
    reg_write(2'd2, 8'h77);
    step(10);
    expect_val("prereset_level", 252); check_obs({24'd0, level});
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    expect_val("midrst_level", 0); check_obs({24'd0, level});
    expect_val("midrst_dout", 0);  check_obs({31'd0, dout});
    expect_val("midrst_acc", 0);   check_obs({24'd0, dut.u_dac.acc});
    step(2);
    rst = 1'b0;
    step(3);
    expect_val("postrst_default_level", 144); check_obs({24'd0, level});

    if (sb.size() != 0) begin
      bad++;
      $error("FAIL scoreboard_leftover: observed=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
